// File: rtl/ball_motion.sv
// Ball state owner: latches ball/paddle scan coincidences during the frame and moves the ball once per frame.
// Latency: new position, goal pulses and in_play appear 1 cycle after the frame_end or serve pulse that causes them.
// Backpressure: none; frame_end, serve and the scan inputs are single-cycle strobes that are always accepted.
//
// Ports:
//   clk, reset                    master clock, synchronous active-high reset
//   frame_end, serve              per-frame advance strobe, launch strobe (used only in IDLE)
//   ball_scan, *_paddle_scan      per-pixel scan activity from the scan generators
//   ball_x, ball_y                ball centre position (10-bit)
//   in_play                       high while a rally is live
//   goal_left, goal_right         1-cycle scoring pulses
//
// Optional feature: define BALL_SPEEDUP_EN to speed the ball up by 1 px/frame on every
// paddle return, saturating at SPEED_MAX. Without it the horizontal step stays at SPEED_X.
module ball_motion #(
   parameter int BALLSIZE    = 8,
   parameter int FIELD_W     = 640,
   parameter int FIELD_H     = 480,
   parameter int SERVE_X     = 320,
   parameter int SERVE_Y     = 240,
   parameter int SPEED_X     = 2,
   parameter int SPEED_Y     = 1,
   parameter int SPEED_MAX   = 7,
   parameter int HOLD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_end,
   input  logic       serve,
   input  logic       ball_scan,
   input  logic       left_paddle_scan,
   input  logic       right_paddle_scan,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       in_play,
   output logic       goal_left,
   output logic       goal_right
);

   localparam int CW = $clog2(HOLD_FRAMES + 1);

   localparam logic [9:0] HALF  = 10'(BALLSIZE / 2);
   localparam logic [9:0] X_MAX = 10'(FIELD_W - 1 - BALLSIZE / 2);
   localparam logic [9:0] Y_MAX = 10'(FIELD_H - 1 - BALLSIZE / 2);
   localparam logic [9:0] SRV_X = 10'(SERVE_X);
   localparam logic [9:0] SRV_Y = 10'(SERVE_Y);
   localparam logic [9:0] STP_Y = 10'(SPEED_Y);
   localparam logic [2:0] STP_X = 3'(SPEED_X);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      SCORED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic [2:0]    step_q, step_d;
   logic          dir_right_q, dir_right_d;   // 1 = moving right
   logic          dir_down_q, dir_down_d;     // 1 = moving down
   logic          srv_right_q, srv_right_d;   // launch direction for the next serve
   logic          hit_l_q, hit_l_d, hit_r_q, hit_r_d;
   logic          gl_q, gl_d, gr_q, gr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          hit_l, hit_r;
   logic [9:0]    step10;
   logic [2:0]    step_bump;

   // A coincidence landing on the frame_end cycle still belongs to the frame being closed.
   assign hit_l  = hit_l_q | (ball_scan & left_paddle_scan);
   assign hit_r  = hit_r_q | (ball_scan & right_paddle_scan);
   assign step10 = {7'd0, step_q};

`ifdef BALL_SPEEDUP_EN
   localparam logic [2:0] STP_MAX = 3'(SPEED_MAX);
   assign step_bump = (step_q >= STP_MAX) ? STP_MAX : step_q + 3'd1;
`else
   assign step_bump = step_q;
`endif

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      step_d      = step_q;
      dir_right_d = dir_right_q;
      dir_down_d  = dir_down_q;
      srv_right_d = srv_right_q;
      cnt_d       = cnt_q;
      gl_d        = 1'b0;
      gr_d        = 1'b0;
      hit_l_d     = frame_end ? 1'b0 : hit_l;
      hit_r_d     = frame_end ? 1'b0 : hit_r;

      unique case (state_q)
         IDLE: begin
            if (serve) begin
               state_d     = PLAY;
               step_d      = STP_X;
               dir_right_d = srv_right_q;
               dir_down_d  = 1'b1;
            end
         end

         PLAY: begin
            if (frame_end) begin
               // Horizontal: only the paddle the ball is heading toward can return it.
               // Limits are tested before stepping so the 10-bit position never wraps.
               if (!dir_right_q) begin
                  if (hit_l) begin
                     dir_right_d = 1'b1;
                     step_d      = step_bump;
                  end else if (x_q < HALF + step10) begin
                     x_d         = HALF;
                     gr_d        = 1'b1;
                     srv_right_d = 1'b0;
                     state_d     = SCORED;
                     cnt_d       = '0;
                  end else begin
                     x_d = x_q - step10;
                  end
               end else begin
                  if (hit_r) begin
                     dir_right_d = 1'b0;
                     step_d      = step_bump;
                  end else if (x_q + step10 > X_MAX) begin
                     x_d         = X_MAX;
                     gl_d        = 1'b1;
                     srv_right_d = 1'b1;
                     state_d     = SCORED;
                     cnt_d       = '0;
                  end else begin
                     x_d = x_q + step10;
                  end
               end

               // Vertical keeps moving even on the frame a goal is scored.
               if (!dir_down_q) begin
                  if (y_q < HALF + STP_Y) begin
                     y_d        = HALF;
                     dir_down_d = 1'b1;
                  end else begin
                     y_d = y_q - STP_Y;
                  end
               end else begin
                  if (y_q + STP_Y > Y_MAX) begin
                     y_d        = Y_MAX;
                     dir_down_d = 1'b0;
                  end else begin
                     y_d = y_q + STP_Y;
                  end
               end
            end
         end

         SCORED: begin
            if (frame_end) begin
               if (cnt_q == HOLD_LAST) begin
                  x_d     = SRV_X;
                  y_d     = SRV_Y;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         x_q         <= SRV_X;
         y_q         <= SRV_Y;
         step_q      <= STP_X;
         dir_right_q <= 1'b1;
         dir_down_q  <= 1'b1;
         srv_right_q <= 1'b1;
         hit_l_q     <= 1'b0;
         hit_r_q     <= 1'b0;
         gl_q        <= 1'b0;
         gr_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         step_q      <= step_d;
         dir_right_q <= dir_right_d;
         dir_down_q  <= dir_down_d;
         srv_right_q <= srv_right_d;
         hit_l_q     <= hit_l_d;
         hit_r_q     <= hit_r_d;
         gl_q        <= gl_d;
         gr_q        <= gr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ball_x     = x_q;
   assign ball_y     = y_q;
   assign in_play    = (state_q == PLAY);
   assign goal_left  = gl_q;
   assign goal_right = gr_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed rally scenarios plus randomized play.
// Every cycle the DUT outputs are compared with a frame-level game model; literal values pin the model.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge before new drive.
module tb_ball_motion;

   localparam int HALF  = 4;
   localparam int XMAX  = 635;
   localparam int YMAX  = 475;
   localparam int SRVX  = 320;
   localparam int SRVY  = 240;
   localparam int SPX   = 2;
   localparam int SPY   = 1;
   localparam int SPMAX = 7;
   localparam int HOLD  = 60;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_end = 1'b0;
   logic       serve = 1'b0;
   logic       ball_scan = 1'b0;
   logic       left_paddle_scan = 1'b0;
   logic       right_paddle_scan = 1'b0;
   logic [9:0] ball_x, ball_y;
   logic       in_play, goal_left, goal_right;

   ball_motion dut (
      .clk               (clk),
      .reset             (reset),
      .frame_end         (frame_end),
      .serve             (serve),
      .ball_scan         (ball_scan),
      .left_paddle_scan  (left_paddle_scan),
      .right_paddle_scan (right_paddle_scan),
      .ball_x            (ball_x),
      .ball_y            (ball_y),
      .in_play           (in_play),
      .goal_left         (goal_left),
      .goal_right        (goal_right)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // ---------------- game model (whole-frame view, signed integers) ----------------
   localparam int M_IDLE = 0, M_PLAY = 1, M_SCORED = 2;
   bit m_valid = 1'b0;
   int m_mode, m_x, m_y, m_dx, m_dy, m_step, m_serve_dx, m_hold;
   bit m_hl, m_hr, m_gl, m_gr;

   function automatic int speed_after_return(int s);
`ifdef BALL_SPEEDUP_EN
      return (s + 1 > SPMAX) ? SPMAX : s + 1;
`else
      return s;
`endif
   endfunction

   task automatic model_step(input bit r, fe, sv, bs, lp, rp);
      bit hl, hr;
      if (r) begin
         m_valid = 1'b1;
         m_mode = M_IDLE; m_x = SRVX; m_y = SRVY; m_dx = 1; m_dy = 1;
         m_step = SPX; m_serve_dx = 1; m_hold = 0;
         m_hl = 0; m_hr = 0; m_gl = 0; m_gr = 0;
         return;
      end
      hl = m_hl || (bs && lp);
      hr = m_hr || (bs && rp);
      m_gl = 0; m_gr = 0;
      if (m_mode == M_IDLE) begin
         if (sv) begin
            m_mode = M_PLAY; m_step = SPX; m_dx = m_serve_dx; m_dy = 1;
         end
      end else if (m_mode == M_PLAY) begin
         if (fe) begin
            if ((m_dx < 0 && hl) || (m_dx > 0 && hr)) begin
               m_dx = -m_dx;
               m_step = speed_after_return(m_step);
            end else begin
               int nx;
               nx = m_x + m_dx * m_step;
               if (nx < HALF) begin
                  m_x = HALF; m_gr = 1; m_serve_dx = -1; m_mode = M_SCORED; m_hold = 0;
               end else if (nx > XMAX) begin
                  m_x = XMAX; m_gl = 1; m_serve_dx = 1; m_mode = M_SCORED; m_hold = 0;
               end else begin
                  m_x = nx;
               end
            end
            begin
               int ny;
               ny = m_y + m_dy * SPY;
               if (ny < HALF)      begin m_y = HALF; m_dy = 1;  end
               else if (ny > YMAX) begin m_y = YMAX; m_dy = -1; end
               else                m_y = ny;
            end
         end
      end else begin
         if (fe) begin
            m_hold++;
            if (m_hold == HOLD) begin
               m_x = SRVX; m_y = SRVY; m_mode = M_IDLE;
            end
         end
      end
      m_hl = fe ? 1'b0 : hl;
      m_hr = fe ? 1'b0 : hr;
   endtask

   // ---------------- checking ----------------
   task automatic compare_model();
      if (!m_valid) return;
      n_cmp++;
      if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || in_play !== (m_mode == M_PLAY) ||
          goal_left !== m_gl || goal_right !== m_gr) begin
         n_err++;
         $display("FAIL model cyc=%0d got x=%0d y=%0d play=%b gl=%b gr=%b exp x=%0d y=%0d play=%b gl=%b gr=%b",
                  cyc, ball_x, ball_y, in_play, goal_left, goal_right,
                  m_x, m_y, (m_mode == M_PLAY), m_gl, m_gr);
      end
   endtask

   task automatic lit(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // One clock: check outputs of the previous edge, then drive and advance the model.
   task automatic cycle(input bit r, fe, sv, bs, lp, rp);
      @(negedge clk);
      cyc++;
      compare_model();
      reset = r; frame_end = fe; serve = sv;
      ball_scan = bs; left_paddle_scan = lp; right_paddle_scan = rp;
      model_step(r, fe, sv, bs, lp, rp);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0);
   endtask

   // Early cycle (optional serve / left coincidence), frame_end cycle (optional hits), one settle cycle.
   // On return the outputs show the result of this frame_end.
   task automatic frame(input bit sv_early, mid_l, fe_l, fe_r);
      cycle(0, 0, sv_early, mid_l, mid_l, 0);
      cycle(0, 1, 0, fe_l | fe_r, fe_l, fe_r);
      idle();
   endtask

   initial begin
      // Reset for two cycles
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      idle();
      lit("reset_x", ball_x, 320);
      lit("reset_y", ball_y, 240);
      lit("reset_in_play", in_play, 0);
      lit("reset_goals", {goal_left, goal_right}, 0);

      // Serve and first three frames
      cycle(0, 0, 1, 0, 0, 0);
      idle();
      lit("serve_in_play", in_play, 1);
      lit("serve_pos_x", ball_x, 320);
      frame(0, 0, 0, 0); lit("f1_x", ball_x, 322); lit("f1_y", ball_y, 241);
      frame(0, 0, 0, 0); lit("f2_x", ball_x, 324); lit("f2_y", ball_y, 242);
      frame(0, 0, 0, 0); lit("f3_x", ball_x, 326); lit("f3_y", ball_y, 243);

      // No returns: right-edge goal on frame 158
      for (int k = 4; k <= 158; k++) frame(0, 0, 0, 0);
      lit("goal_x", ball_x, 635);
      lit("goal_y", ball_y, 398);
      lit("goal_left_pulse", goal_left, 1);
      lit("goal_right_quiet", goal_right, 0);
      lit("goal_in_play", in_play, 0);
      idle();
      lit("goal_left_one_cycle", goal_left, 0);

      // Hold: serve pulses are ignored while scored
      for (int k = 1; k < HOLD; k++) frame(1, 0, 0, 0);
      lit("hold_x", ball_x, 635);
      lit("hold_in_play", in_play, 0);
      frame(1, 0, 0, 0);
      lit("reload_x", ball_x, 320);
      lit("reload_y", ball_y, 240);
      lit("reload_in_play", in_play, 0);

      // New serve goes right again
      cycle(0, 0, 1, 0, 0, 0);
      frame(0, 0, 0, 0);
      lit("reserve_x", ball_x, 322);
      lit("reserve_y", ball_y, 241);

      // Rally with automatic returns
      begin
         bit hr, hl, mid;
         for (int k = 2; k <= 240; k++) begin
            hr  = (m_dx > 0) && (m_x + m_step > 600);
            hl  = (m_dx < 0) && (m_x - m_step < 40);
            mid = (k == 11);   // left coincidence while heading right
            frame(0, mid, hl, hr);
            if (k == 10)  lit("pre_wrong_hit_x", ball_x, 340);
            if (k == 11)  lit("wrong_hit_ignored_x", ball_x, 342);
            if (k == 141) lit("right_return_x", ball_x, 600);
`ifdef BALL_SPEEDUP_EN
            if (k == 142) lit("after_return_x", ball_x, 597);
`else
            if (k == 142) lit("after_return_x", ball_x, 598);
`endif
            if (k == 235) lit("wall_y_235", ball_y, 475);
            if (k == 236) lit("wall_y_clamp", ball_y, 475);
            if (k == 237) lit("wall_y_up", ball_y, 474);
         end
      end
      lit("rally_in_play", in_play, 1);

      // Reset mid-rally
      cycle(1, 0, 0, 0, 0, 0);
      idle();
      lit("midreset_x", ball_x, 320);
      lit("midreset_y", ball_y, 240);
      lit("midreset_in_play", in_play, 0);

      // Randomized play
      begin
         int fcnt;
         bit r, fe, sv, bs, lp, rp;
         fcnt = 4;
         for (int i = 0; i < 30000; i++) begin
            fe = (fcnt == 0);
            fcnt = fe ? int'($urandom_range(2, 6)) : fcnt - 1;
            r  = ($urandom_range(0, 1999) == 0);
            sv = ($urandom_range(0, 24) == 0);
            bs = ($urandom_range(0, 3) == 0);
            lp = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 5) == 0);
            cycle(r, fe, sv, bs, lp, rp);
         end
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
